// File: rtl/param_reservation_station_if.sv
// rtl/param_reservation_station_if.sv - decoder, CDB and ALU bundle for the reservation station
// Ports: dec_* insert side with dec_full back-pressure; cdb_* packed broadcast
// channels (channel c uses [c*W +: W]); alu_* issue side with alu_ready
// back-pressure; count occupancy. Modport master = environment, slave = station.
interface param_reservation_station_if #(
    parameter int DEPTH  = 8,
    parameter int ROB_W  = 4,
    parameter int TYPE_W = 5,
    parameter int XLEN   = 32,
    parameter int NCDB   = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                   dec_full;
    logic                   dec_rdy;
    logic [TYPE_W-1:0]      dec_type;
    logic [XLEN-1:0]        dec_data_j;
    logic [XLEN-1:0]        dec_data_k;
    logic                   dec_pending_j;
    logic                   dec_pending_k;
    logic [ROB_W-1:0]       dec_dep_j;
    logic [ROB_W-1:0]       dec_dep_k;
    logic [ROB_W-1:0]       dec_rob_id;
    logic [XLEN-1:0]        dec_imm;
    logic [NCDB-1:0]        cdb_en;
    logic [NCDB*ROB_W-1:0]  cdb_rob_id;
    logic [NCDB*XLEN-1:0]   cdb_data;
    logic                   alu_en;
    logic                   alu_ready;
    logic [TYPE_W-1:0]      alu_type;
    logic [ROB_W-1:0]       alu_rob_id;
    logic [XLEN-1:0]        alu_data_j;
    logic [XLEN-1:0]        alu_data_k;
    logic [XLEN-1:0]        alu_imm;
    logic [CW-1:0]          count;

    modport master (
        input  dec_full, alu_en, alu_type, alu_rob_id, alu_data_j, alu_data_k, alu_imm, count,
        output dec_rdy, dec_type, dec_data_j, dec_data_k, dec_pending_j, dec_pending_k,
               dec_dep_j, dec_dep_k, dec_rob_id, dec_imm, cdb_en, cdb_rob_id, cdb_data,
               alu_ready
    );

    modport slave (
        output dec_full, alu_en, alu_type, alu_rob_id, alu_data_j, alu_data_k, alu_imm, count,
        input  dec_rdy, dec_type, dec_data_j, dec_data_k, dec_pending_j, dec_pending_k,
               dec_dep_j, dec_dep_k, dec_rob_id, dec_imm, cdb_en, cdb_rob_id, cdb_data,
               alu_ready
    );
endinterface

// File: rtl/param_reservation_station.sv
// rtl/param_reservation_station.sv - parametrised ALU reservation station with multi-channel CDB wakeup
// Ports: clk_in clock; rst_in synchronous active-high reset; rdy_in global enable
// (low = hold all state, no issue); flush discards all entries; bus is the
// slave side of param_reservation_station_if (decoder insert, CDB, ALU issue, count).
// Macro RS_AGE_SELECT_EN: defined = oldest-ready-first selection via an age
// matrix; undefined = lowest-index ready entry.
module param_reservation_station #(
    parameter int DEPTH  = 8,
    parameter int ROB_W  = 4,
    parameter int TYPE_W = 5,
    parameter int XLEN   = 32,
    parameter int NCDB   = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic flush,
    param_reservation_station_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   pend_j_q;
    logic [DEPTH-1:0]   pend_k_q;
    logic [TYPE_W-1:0]  type_q   [DEPTH];
    logic [XLEN-1:0]    data_j_q [DEPTH];
    logic [XLEN-1:0]    data_k_q [DEPTH];
    logic [ROB_W-1:0]   dep_j_q  [DEPTH];
    logic [ROB_W-1:0]   dep_k_q  [DEPTH];
    logic [ROB_W-1:0]   rob_q    [DEPTH];
    logic [XLEN-1:0]    imm_q    [DEPTH];
    logic [CW-1:0]      count_q;
`ifdef RS_AGE_SELECT_EN
    // age_q[i][j] set: entry i is older than entry j
    logic [DEPTH-1:0]   age_q    [DEPTH];
`endif

    logic [DEPTH-1:0]   ready;
    logic               sel_found;
    logic [IW-1:0]      sel_idx;
    logic               free_found;
    logic [IW-1:0]      free_idx;
    logic               full;
    logic               ins;
    logic               iss;
    logic               ins_pend_j;
    logic               ins_pend_k;
    logic [XLEN-1:0]    ins_data_j;
    logic [XLEN-1:0]    ins_data_k;

    assign full = (count_q == CW'(DEPTH));
    assign ins  = bus.dec_rdy && !full && !flush && rdy_in;
    assign iss  = bus.alu_en && bus.alu_ready;

    // Lowest-index free slot: scan downward so the lowest hit is written last.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    // Same-cycle bypass of a CDB broadcast into the instruction being inserted.
    // Channels are scanned high to low so the lowest matching channel wins.
    always_comb begin
        ins_pend_j = bus.dec_pending_j;
        ins_pend_k = bus.dec_pending_k;
        ins_data_j = bus.dec_data_j;
        ins_data_k = bus.dec_data_k;
        for (int c = NCDB - 1; c >= 0; c--) begin
            if (bus.dec_pending_j && bus.cdb_en[c] &&
                bus.cdb_rob_id[c*ROB_W +: ROB_W] == bus.dec_dep_j) begin
                ins_pend_j = 1'b0;
                ins_data_j = bus.cdb_data[c*XLEN +: XLEN];
            end
            if (bus.dec_pending_k && bus.cdb_en[c] &&
                bus.cdb_rob_id[c*ROB_W +: ROB_W] == bus.dec_dep_k) begin
                ins_pend_k = 1'b0;
                ins_data_k = bus.cdb_data[c*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        ready     = valid_q & ~pend_j_q & ~pend_k_q;
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef RS_AGE_SELECT_EN
        // Pick the ready entry that no other ready entry is older than.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && age_q[j][i]) blocked = 1'b1;
            end
            if (ready[i] && !blocked) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
`else
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
`endif
    end

    assign bus.dec_full   = full;
    assign bus.count      = count_q;
    assign bus.alu_en     = rdy_in && sel_found;
    assign bus.alu_type   = bus.alu_en ? type_q[sel_idx]   : '0;
    assign bus.alu_rob_id = bus.alu_en ? rob_q[sel_idx]    : '0;
    assign bus.alu_data_j = bus.alu_en ? data_j_q[sel_idx] : '0;
    assign bus.alu_data_k = bus.alu_en ? data_k_q[sel_idx] : '0;
    assign bus.alu_imm    = bus.alu_en ? imm_q[sel_idx]    : '0;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q  <= '0;
            pend_j_q <= '0;
            pend_k_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                type_q[i]   <= '0;
                data_j_q[i] <= '0;
                data_k_q[i] <= '0;
                dep_j_q[i]  <= '0;
                dep_k_q[i]  <= '0;
                rob_q[i]    <= '0;
                imm_q[i]    <= '0;
`ifdef RS_AGE_SELECT_EN
                age_q[i]    <= '0;
`endif
            end
        end else if (rdy_in) begin
            // Wakeup; later (lower-index) channel assignments override earlier ones.
            for (int i = 0; i < DEPTH; i++) begin
                for (int c = NCDB - 1; c >= 0; c--) begin
                    if (valid_q[i] && pend_j_q[i] && bus.cdb_en[c] &&
                        bus.cdb_rob_id[c*ROB_W +: ROB_W] == dep_j_q[i]) begin
                        pend_j_q[i] <= 1'b0;
                        data_j_q[i] <= bus.cdb_data[c*XLEN +: XLEN];
                    end
                    if (valid_q[i] && pend_k_q[i] && bus.cdb_en[c] &&
                        bus.cdb_rob_id[c*ROB_W +: ROB_W] == dep_k_q[i]) begin
                        pend_k_q[i] <= 1'b0;
                        data_k_q[i] <= bus.cdb_data[c*XLEN +: XLEN];
                    end
                end
            end

            if (iss) valid_q[sel_idx] <= 1'b0;

            if (flush) begin
                valid_q <= '0;
                count_q <= '0;
            end else begin
                if (ins) begin
                    valid_q[free_idx]  <= 1'b1;
                    pend_j_q[free_idx] <= ins_pend_j;
                    pend_k_q[free_idx] <= ins_pend_k;
                    type_q[free_idx]   <= bus.dec_type;
                    data_j_q[free_idx] <= ins_data_j;
                    data_k_q[free_idx] <= ins_data_k;
                    dep_j_q[free_idx]  <= bus.dec_dep_j;
                    dep_k_q[free_idx]  <= bus.dec_dep_k;
                    rob_q[free_idx]    <= bus.dec_rob_id;
                    imm_q[free_idx]    <= bus.dec_imm;
`ifdef RS_AGE_SELECT_EN
                    // Every currently valid entry is older than the newcomer.
                    for (int j = 0; j < DEPTH; j++) begin
                        age_q[j][free_idx] <= valid_q[j];
                    end
                    age_q[free_idx] <= '0;
`endif
                end
                count_q <= count_q + (ins ? CW'(1) : CW'(0)) - (iss ? CW'(1) : CW'(0));
            end
        end
    end
endmodule

// File: tb/tb_param_reservation_station.sv
// tb/tb_param_reservation_station.sv - directed self-checking bench for param_reservation_station
module tb_param_reservation_station;
    localparam int DEPTH = 8;
    localparam int ROB_W = 4;
    localparam int TYPE_W = 5;
    localparam int XLEN = 32;
    localparam int NCDB = 2;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    logic flush;
    int   tests = 0;
    int   fails = 0;
    int   exp_first;
    int   exp_second;

    param_reservation_station_if #(
        .DEPTH(DEPTH), .ROB_W(ROB_W), .TYPE_W(TYPE_W), .XLEN(XLEN), .NCDB(NCDB)
    ) bus ();

    param_reservation_station #(
        .DEPTH(DEPTH), .ROB_W(ROB_W), .TYPE_W(TYPE_W), .XLEN(XLEN), .NCDB(NCDB)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample #1 later, then drop one-cycle pulse inputs.
    task automatic tick();
        @(posedge clk_in);
        #1;
        bus.dec_rdy = 1'b0;
        bus.cdb_en  = '0;
        flush       = 1'b0;
    endtask

    task automatic dec(input logic [3:0] rob, input logic [31:0] dj, input logic [31:0] dk,
                       input logic pj, input logic [3:0] tj, input logic pk, input logic [3:0] tk);
        bus.dec_rdy       = 1'b1;
        bus.dec_type      = 5'd1;
        bus.dec_rob_id    = rob;
        bus.dec_data_j    = dj;
        bus.dec_data_k    = dk;
        bus.dec_pending_j = pj;
        bus.dec_dep_j     = tj;
        bus.dec_pending_k = pk;
        bus.dec_dep_k     = tk;
        bus.dec_imm       = 32'h20;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0;
        bus.dec_rdy = 0; bus.dec_type = 0; bus.dec_data_j = 0; bus.dec_data_k = 0;
        bus.dec_pending_j = 0; bus.dec_pending_k = 0; bus.dec_dep_j = 0; bus.dec_dep_k = 0;
        bus.dec_rob_id = 0; bus.dec_imm = 0; bus.cdb_en = 0; bus.cdb_rob_id = 0;
        bus.cdb_data = 0; bus.alu_ready = 0;
        tick(); tick();
        rst_in = 1'b0;
        chk("reset_count", 64'(bus.count), 0);
        chk("reset_full", 64'(bus.dec_full), 0);
        chk("reset_alu_en", 64'(bus.alu_en), 0);
        chk("reset_payload", 64'(bus.alu_rob_id), 0);

        // Ready instruction offered the next cycle and issued.
        dec(4'd3, 32'd5, 32'd7, 0, 0, 0, 0);
        tick();
        chk("a_alu_en", 64'(bus.alu_en), 1);
        chk("a_rob", 64'(bus.alu_rob_id), 3);
        chk("a_data_j", 64'(bus.alu_data_j), 5);
        chk("a_data_k", 64'(bus.alu_data_k), 7);
        chk("a_imm", 64'(bus.alu_imm), 32'h20);
        chk("a_count", 64'(bus.count), 1);
        bus.alu_ready = 1;
        tick();
        chk("a_count_after", 64'(bus.count), 0);
        chk("a_en_after", 64'(bus.alu_en), 0);
        chk("a_payload_zero", 64'(bus.alu_data_j), 0);
        bus.alu_ready = 0;

        // Wakeup on channel 1 two cycles after insert.
        dec(4'd4, 32'd0, 32'd1, 1, 4'd2, 0, 0);
        tick();
        chk("b_wait_en", 64'(bus.alu_en), 0);
        tick();
        bus.cdb_en = 2'b10; bus.cdb_rob_id = {4'd2, 4'd0}; bus.cdb_data = {32'h11, 32'h0};
        tick();
        chk("b_woken_en", 64'(bus.alu_en), 1);
        chk("b_data_j", 64'(bus.alu_data_j), 32'h11);
        chk("b_rob", 64'(bus.alu_rob_id), 4);
        bus.alu_ready = 1;
        tick();
        bus.alu_ready = 0;

        // Same-cycle bypass on channel 0.
        dec(4'd5, 32'd3, 32'd0, 0, 0, 1, 4'd4);
        bus.cdb_en = 2'b01; bus.cdb_rob_id = {4'd9, 4'd4}; bus.cdb_data = {32'h0, 32'd9};
        tick();
        chk("c_en", 64'(bus.alu_en), 1);
        chk("c_data_k", 64'(bus.alu_data_k), 9);
        bus.alu_ready = 1;
        tick();
        bus.alu_ready = 0;
        chk("c_count", 64'(bus.count), 0);

        // Fill to DEPTH, extra insert ignored, slot reusable only after issue.
        for (int i = 0; i < DEPTH; i++) begin
            dec(4'(i), 32'(i), 32'd0, 0, 0, 0, 0);
            tick();
        end
        chk("fill_count", 64'(bus.count), DEPTH);
        chk("fill_full", 64'(bus.dec_full), 1);
        chk("fill_head", 64'(bus.alu_rob_id), 0);
        dec(4'd15, 32'd0, 32'd0, 0, 0, 0, 0);
        tick();
        chk("full_ignore", 64'(bus.count), DEPTH);
        bus.alu_ready = 1;
        tick();
        chk("drain1_count", 64'(bus.count), DEPTH - 1);
        chk("drain1_full", 64'(bus.dec_full), 0);
        chk("drain1_next", 64'(bus.alu_rob_id), 1);
        for (int i = 0; i < DEPTH - 1; i++) tick();
        chk("drain_count", 64'(bus.count), 0);
        chk("drain_en", 64'(bus.alu_en), 0);
        bus.alu_ready = 0;

        // Age ordering: rob 1 older in slot 1, rob 2 younger in slot 0.
        dec(4'd9, 32'd0, 32'd0, 0, 0, 0, 0);
        tick();
        dec(4'd1, 32'd0, 32'd0, 1, 4'd5, 0, 0);
        tick();
        chk("age_filler", 64'(bus.alu_rob_id), 9);
        bus.alu_ready = 1;
        tick();
        bus.alu_ready = 0;
        chk("age_count1", 64'(bus.count), 1);
        dec(4'd2, 32'd0, 32'd0, 1, 4'd6, 0, 0);
        tick();
        chk("age_none_ready", 64'(bus.alu_en), 0);
        bus.cdb_en = 2'b11; bus.cdb_rob_id = {4'd6, 4'd5}; bus.cdb_data = {32'hB, 32'hA};
        tick();
`ifdef RS_AGE_SELECT_EN
        exp_first = 1; exp_second = 2;
`else
        exp_first = 2; exp_second = 1;
`endif
        chk("age_first", 64'(bus.alu_rob_id), 64'(exp_first));
        bus.alu_ready = 1;
        tick();
        chk("age_second", 64'(bus.alu_rob_id), 64'(exp_second));
        tick();
        bus.alu_ready = 0;
        chk("age_count0", 64'(bus.count), 0);

        // Flush at occupancy 5 with a same-cycle insert.
        for (int i = 0; i < 5; i++) begin
            dec(4'(i), 32'd0, 32'd0, 1, 4'd15, 0, 0);
            tick();
        end
        chk("pre_flush_count", 64'(bus.count), 5);
        dec(4'd6, 32'd1, 32'd2, 0, 0, 0, 0);
        flush = 1;
        tick();
        chk("flush_count", 64'(bus.count), 0);
        chk("flush_en", 64'(bus.alu_en), 0);
        bus.cdb_en = 2'b01; bus.cdb_rob_id = {4'd0, 4'd15}; bus.cdb_data = 0;
        tick();
        chk("flush_gone", 64'(bus.alu_en), 0);

        // Global enable low holds state and suppresses issue.
        dec(4'd7, 32'd0, 32'd0, 0, 0, 0, 0);
        tick();
        rdy_in = 0; bus.alu_ready = 1;
        dec(4'd8, 32'd0, 32'd0, 0, 0, 0, 0);
        tick();
        chk("hold_en", 64'(bus.alu_en), 0);
        chk("hold_count", 64'(bus.count), 1);
        rdy_in = 1;
        #1;
        chk("resume_rob", 64'(bus.alu_rob_id), 7);
        tick();
        chk("resume_count", 64'(bus.count), 0);
        bus.alu_ready = 0;

        // Reset beats a same-cycle insert.
        dec(4'd3, 32'd0, 32'd0, 0, 0, 0, 0);
        tick();
        rst_in = 1;
        dec(4'd4, 32'd0, 32'd0, 0, 0, 0, 0);
        tick();
        rst_in = 0;
        chk("rst_count", 64'(bus.count), 0);
        chk("rst_en", 64'(bus.alu_en), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
